// File: rtl/paddle2quad_pkg.sv
// paddle2quad shared types and constants.
// Imported by the tracker top and the phase sub-module.
package paddle2quad_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        STEP = 1'b1
    } state_e;

    localparam logic [7:0] POS_CENTRE = 8'h80;

    // Packed Gray table, entry n at bits [2n+1:2n]: 00,01,11,10
    localparam logic [7:0] GRAY_TBL = 8'b10_11_01_00;

    function automatic logic [1:0] gray(input logic [1:0] ph);
        return GRAY_TBL[{ph, 1'b0} +: 2];
    endfunction

endpackage

// File: rtl/paddle2quad_quad_phase.sv
// quad_phase: 2-bit up/down phase counter with Gray-coded output.
// One instance per player channel.
module quad_phase
    import paddle2quad_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       up,
    input  logic       dn,
    input  logic       hold,
    output logic [1:0] steer
);

    logic [1:0] ph_q;
    logic [1:0] ph_d;

    always_comb begin
        ph_d = ph_q;
        if (!hold) begin
            if (up && !dn) begin
                ph_d = ph_q + 2'd1;
            end else if (dn && !up) begin
                ph_d = ph_q - 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ph_q <= 2'd0;
        end else begin
            ph_q <= ph_d;
        end
    end

    assign steer = gray(ph_q);

endmodule

// File: rtl/paddle2quad.sv
// paddle2quad: rate-limited tracker turning an absolute paddle
// position into a quadrature step stream for the core encoder.
module paddle2quad
    import paddle2quad_pkg::*;
#(
    parameter int CLKDIV   = 5500,
    parameter int DEADBAND = 2
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       enable,
    input  logic [7:0] paddle,
    output logic [1:0] steer,
    output logic [7:0] pos,
    output logic       busy
);

    localparam int DW = (CLKDIV > 2) ? $clog2(CLKDIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLKDIV - 1);

    logic [7:0]    p_q;
    logic [7:0]    tgt_q, tgt_d;
    logic [7:0]    cur_q, cur_d;
    logic [DW-1:0] div_q, div_d;
    state_e        state_q, state_d;
    logic          en_q;

    logic              rise;
    logic              tick;
    logic              step_up;
    logic              step_dn;
    logic              retgt;
    logic signed [8:0] diff;
    logic        [8:0] mag;

    assign rise = enable & ~en_q;
    assign tick = enable & (div_q == DIV_LAST);

    // 9-bit signed difference: no wrap between 0x00 and 0xFF
    assign diff  = $signed({1'b0, p_q}) - $signed({1'b0, tgt_q});
    assign mag   = diff[8] ? $unsigned(-diff) : $unsigned(diff);
    assign retgt = (mag > 9'(DEADBAND));

    assign step_up = enable & ~rise & tick
                   & (state_q == STEP) & (cur_q < tgt_q);
    assign step_dn = enable & ~rise & tick
                   & (state_q == STEP) & (cur_q > tgt_q);

    always_comb begin
        div_d   = div_q;
        cur_d   = cur_q;
        tgt_d   = tgt_q;
        state_d = state_q;
        if (!enable || rise || tick) begin
            div_d = '0;
        end else begin
            div_d = div_q + DW'(1);
        end
        if (rise) begin
            cur_d   = p_q;
            tgt_d   = p_q;
            state_d = IDLE;
        end else if (enable) begin
            // Step uses the pre-retarget tgt when both land together
            if (step_up) begin
                cur_d = cur_q + 8'd1;
            end else if (step_dn) begin
                cur_d = cur_q - 8'd1;
            end
            if (retgt) begin
                tgt_d = p_q;
            end
            unique case (state_q)
                IDLE: if (cur_q != tgt_q) state_d = STEP;
                STEP: if (cur_q == tgt_q) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_sys) begin
        p_q <= paddle;
        if (reset) begin
            tgt_q   <= POS_CENTRE;
            cur_q   <= POS_CENTRE;
            div_q   <= '0;
            state_q <= IDLE;
            en_q    <= 1'b0;
        end else begin
            tgt_q   <= tgt_d;
            cur_q   <= cur_d;
            div_q   <= div_d;
            state_q <= state_d;
            en_q    <= enable;
        end
    end

    quad_phase u_phase (
        .clk   (clk_sys),
        .reset (reset),
        .up    (step_up),
        .dn    (step_dn),
        .hold  (~enable | rise),
        .steer (steer)
    );

    assign pos  = cur_q;
    assign busy = (state_q == STEP);

endmodule

// File: tb/tb_paddle2quad.sv
// Randomized bench for paddle2quad against a behavioural tracker
// model, plus directed scenarios for reset, deadband and resync.
module tb_paddle2quad;

    localparam int CLKDIV   = 4;
    localparam int DEADBAND = 2;

    logic       clk_sys;
    logic       reset;
    logic       enable;
    logic [7:0] paddle;
    logic [1:0] steer;
    logic [7:0] pos;
    logic       busy;

    int n_vec;
    int n_bad;

    int m_p, m_tgt, m_cur, m_ph, m_n, m_busy, m_en;
    int gtab [4] = '{0, 1, 3, 2};

    paddle2quad #(
        .CLKDIV   (CLKDIV),
        .DEADBAND (DEADBAND)
    ) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .enable  (enable),
        .paddle  (paddle),
        .steer   (steer),
        .pos     (pos),
        .busy    (busy)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, obs, exp, $time);
        end
    endtask

    // Tracker semantics: busy mirrors "cur differed from tgt" one
    // cycle late; steps happen every CLKDIV enabled cycles.
    task automatic model_step(input logic r, input logic e,
                              input logic [7:0] p);
        int d, nt, nc, nph, nb;
        if (r) begin
            m_tgt = 128; m_cur = 128; m_ph = 0;
            m_n = 0; m_busy = 0; m_en = 0;
        end else if (e && !m_en) begin
            m_cur = m_p; m_tgt = m_p; m_n = 0; m_busy = 0;
            m_en = 1;
        end else if (e) begin
            d  = m_p - m_tgt;
            if (d < 0) d = -d;
            nt  = (d > DEADBAND) ? m_p : m_tgt;
            nc  = m_cur;
            nph = m_ph;
            if (m_busy != 0 && (m_n % CLKDIV) == CLKDIV - 1) begin
                if (m_cur < m_tgt) begin
                    nc = m_cur + 1; nph = (m_ph + 1) % 4;
                end else if (m_cur > m_tgt) begin
                    nc = m_cur - 1; nph = (m_ph + 3) % 4;
                end
            end
            nb = (m_cur != m_tgt) ? 1 : 0;
            m_tgt = nt; m_cur = nc; m_ph = nph; m_busy = nb;
            m_n++;
            m_en = 1;
        end else begin
            m_n = 0;
            m_en = 0;
        end
        m_p = int'(p);
    endtask

    task automatic cyc(input logic r, input logic e,
                       input logic [7:0] p);
        reset = r; enable = e; paddle = p;
        @(posedge clk_sys);
        model_step(r, e, p);
        @(negedge clk_sys);
        chk("steer", 32'(steer), 32'(gtab[m_ph]));
        chk("pos", 32'(pos), 32'(m_cur));
        chk("busy", 32'(busy), 32'(m_busy));
    endtask

    task automatic hold(input int n, input logic e, input logic [7:0] p);
        for (int i = 0; i < n; i++) cyc(1'b0, e, p);
    endtask

    initial begin
        logic [7:0] pv;
        logic [1:0] s0;
        int toggles;
        n_vec = 0; n_bad = 0;
        m_p = 0; m_tgt = 128; m_cur = 128; m_ph = 0;
        m_n = 0; m_busy = 0; m_en = 0;
        reset = 1'b1; enable = 1'b0; paddle = 8'h00;
        @(negedge clk_sys);

        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 8'h00);
        chk("rst_steer", 32'(steer), 32'h0);
        chk("rst_pos", 32'(pos), 32'h80);
        chk("rst_busy", 32'(busy), 32'h0);

        hold(2, 1'b0, 8'h80);
        hold(10, 1'b1, 8'h80);
        hold(30, 1'b1, 8'h84);
        chk("fwd_pos", 32'(pos), 32'h84);
        chk("fwd_busy", 32'(busy), 32'h0);
        chk("fwd_steer", 32'(steer), 32'h0);

        hold(30, 1'b1, 8'h80);
        s0 = steer;
        hold(50, 1'b1, 8'h82);
        chk("db_pos", 32'(pos), 32'h80);
        chk("db_steer", 32'(steer), 32'(s0));
        chk("db_busy", 32'(busy), 32'h0);
        hold(30, 1'b1, 8'h83);
        chk("db_pos3", 32'(pos), 32'h83);

        hold(30, 1'b1, 8'h80);
        hold(2, 1'b1, 8'h90);
        while (pos != 8'h83 && n_vec < 3000) cyc(1'b0, 1'b1, 8'h90);
        hold(40, 1'b1, 8'h7E);
        chk("rev_pos", 32'(pos), 32'h7E);

        hold(3, 1'b0, 8'h20);
        hold(2, 1'b1, 8'h20);
        chk("sync_pos", 32'(pos), 32'h20);
        chk("sync_busy", 32'(busy), 32'h0);
        s0 = steer;
        toggles = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1'b0, 1'b1, 8'h20);
            if (steer != s0) toggles++;
        end
        chk("sync_quiet", 32'(toggles), 32'h0);

        hold(5, 1'b1, 8'h80);
        hold(30, 1'b1, 8'hF0);
        cyc(1'b1, 1'b1, 8'hF0);
        chk("mrst_pos", 32'(pos), 32'h80);
        chk("mrst_steer", 32'(steer), 32'h0);
        chk("mrst_busy", 32'(busy), 32'h0);

        pv = 8'h80;
        for (int s = 0; s < 60; s++) begin
            if ($urandom_range(0, 29) == 0) begin
                cyc(1'b1, 1'b0, pv);
            end
            if ($urandom_range(0, 2) == 0) begin
                pv = pv + 8'($urandom_range(0, 8)) - 8'd4;
            end else begin
                pv = 8'($urandom);
            end
            hold($urandom_range(1, 60), $urandom_range(0, 7) != 0, pv);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule
